// File: rtl/fb_pkg.sv
// Shared types and constants for the frame buffer controller.
package fb_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    localparam int RGB8_W       = $bits(rgb8_t);
    localparam int SCREEN_COORD = 12;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/fb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module fb_rr_arbiter
    import fb_pkg::*;
#(
    parameter int N = 4
)(
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          hit;

    // Search from the pointer, wrapping, and grant the first active request.
    always_comb begin
        grant = '0;
        gidx  = '0;
        hit   = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!hit && req[(int'(ptr) + k) % N]) begin
                grant[(int'(ptr) + k) % N] = 1'b1;
                gidx = PW'((int'(ptr) + k) % N);
                hit  = 1'b1;
            end
        end
    end

    // Move the pointer past the granted channel; hold it when nobody asks.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (hit) begin
            ptr <= (gidx == PW'(N - 1)) ? '0 : gidx + 1'b1;
        end
    end

endmodule

// File: rtl/frame_buffer_mc_controller.sv
// Frame buffer controller: arbitrated pixel writes, pipelined scan-out reads, hardware clear.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | writers arbitrated, pixel writes reach the RAM
// ST_CLEAR | one fill word per cycle, all writers stalled
module frame_buffer_mc_controller
    import fb_pkg::*;
#(
    parameter  int WIDTH       = 160,
    parameter  int HEIGHT      = 120,
    parameter  int NUM_WRITERS = 4,
    parameter  int COLOR_W     = RGB8_W,
    localparam int ADDR_W      = $clog2(WIDTH * HEIGHT)
)(
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_WRITERS-1:0]                     wr_valid,
    output logic [NUM_WRITERS-1:0]                     wr_ready,
    input  logic [NUM_WRITERS-1:0][SCREEN_COORD-1:0]   wr_x,
    input  logic [NUM_WRITERS-1:0][SCREEN_COORD-1:0]   wr_y,
    input  logic [NUM_WRITERS-1:0][COLOR_W-1:0]        wr_color,
    input  logic                                       rd_en,
    input  logic [SCREEN_COORD-1:0]                    rd_x,
    input  logic [SCREEN_COORD-1:0]                    rd_y,
    output logic                                       rd_valid,
    output logic [COLOR_W-1:0]                         rd_color,
    input  logic                                       clear_req,
    input  logic [COLOR_W-1:0]                         clear_color,
    output logic                                       clear_busy,
    output logic                                       clear_done,
    output logic [15:0]                                oob_count
);

    localparam int                      DEPTH     = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [SCREEN_COORD-1:0] WIDTH_C   = SCREEN_COORD'(WIDTH);
    localparam logic [SCREEN_COORD-1:0] HEIGHT_C  = SCREEN_COORD'(HEIGHT);

    logic [0:0]              state;
    logic [ADDR_W-1:0]       clr_cnt;
    logic [COLOR_W-1:0]      clr_color;
    logic [COLOR_W-1:0]      mem [DEPTH];

    logic [NUM_WRITERS-1:0]  req;
    logic [NUM_WRITERS-1:0]  grant;
    logic [SCREEN_COORD-1:0] sel_x;
    logic [SCREEN_COORD-1:0] sel_y;
    logic [COLOR_W-1:0]      sel_color;
    logic                    sel_oob;
    logic [ADDR_W-1:0]       sel_addr;

    logic                    wq_en;
    logic [ADDR_W-1:0]       wq_addr;
    logic [COLOR_W-1:0]      wq_data;

    logic                    rd_oob;
    logic [ADDR_W-1:0]       rd_addr;
    logic                    r1_valid;
    logic                    r1_oob;
    logic [COLOR_W-1:0]      r1_data;

    // Writers only compete while idle and out of reset.
    assign req      = (state == ST_IDLE && !reset) ? wr_valid : '0;
    assign wr_ready = grant;

    fb_rr_arbiter #(.N(NUM_WRITERS)) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .grant (grant)
    );

    // Route the granted channel's pixel onto the write path.
    always_comb begin
        sel_x     = '0;
        sel_y     = '0;
        sel_color = '0;
        for (int i = 0; i < NUM_WRITERS; i++) begin
            if (grant[i]) begin
                sel_x     = wr_x[i];
                sel_y     = wr_y[i];
                sel_color = wr_color[i];
            end
        end
    end

    assign sel_oob  = (sel_x >= WIDTH_C) || (sel_y >= HEIGHT_C);
    assign sel_addr = ADDR_W'(32'(sel_y) * 32'(WIDTH) + 32'(sel_x));
    assign rd_oob   = (rd_x >= WIDTH_C) || (rd_y >= HEIGHT_C);
    assign rd_addr  = ADDR_W'(32'(rd_y) * 32'(WIDTH) + 32'(rd_x));

    assign clear_busy = (state == ST_CLEAR);

    // Clear sequencer: latch the fill colour, sweep the surface, pulse done after the last word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clr_color  <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state     <= ST_CLEAR;
                        clr_color <= clear_color;
                        clr_cnt   <= '0;
                    end
                end
                default: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == LAST_ADDR) begin
                        state      <= ST_IDLE;
                        clear_done <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Handshake stage: register the accepted pixel and count dropped out-of-range writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            wq_en     <= 1'b0;
            oob_count <= '0;
        end else begin
            wq_en <= (|grant) && !sel_oob;
            if ((|grant) && sel_oob && oob_count != 16'hFFFF) begin
                oob_count <= oob_count + 16'd1;
            end
        end
    end

    // Write-stage payload needs no reset; wq_en qualifies it.
    always_ff @(posedge clk) begin
        wq_addr <= sel_addr;
        wq_data <= sel_color;
    end

    // RAM port A. A pixel accepted on the clear-accept edge lands in the first fill
    // cycle and is dropped; the sweep overwrites that address anyway.
    always_ff @(posedge clk) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt] <= clr_color;
        end else if (wq_en) begin
            mem[wq_addr] <= wq_data;
        end
    end

    // RAM port B, first read register.
    always_ff @(posedge clk) begin
        r1_data <= mem[rd_oob ? '0 : rd_addr];
        r1_oob  <= rd_oob;
    end

    // Read output register: out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r1_valid <= 1'b0;
            rd_valid <= 1'b0;
            rd_color <= '0;
        end else begin
            r1_valid <= rd_en;
            rd_valid <= r1_valid;
            if (r1_valid) begin
                rd_color <= r1_oob ? '0 : r1_data;
            end
        end
    end

endmodule

// File: tb/tb_frame_buffer_mc_controller.sv
// Directed self-checking bench for frame_buffer_mc_controller (32x4 surface, 4 writers).
module tb_frame_buffer_mc_controller;
    import fb_pkg::*;

    localparam int W  = 32;
    localparam int H  = 4;
    localparam int NW = 4;
    localparam int CW = 24;

    logic                                  clk = 1'b0;
    logic                                  reset;
    logic [NW-1:0]                         wr_valid;
    logic [NW-1:0]                         wr_ready;
    logic [NW-1:0][SCREEN_COORD-1:0]       wr_x;
    logic [NW-1:0][SCREEN_COORD-1:0]       wr_y;
    logic [NW-1:0][CW-1:0]                 wr_color;
    logic                                  rd_en;
    logic [SCREEN_COORD-1:0]               rd_x;
    logic [SCREEN_COORD-1:0]               rd_y;
    logic                                  rd_valid;
    logic [CW-1:0]                         rd_color;
    logic                                  clear_req;
    logic [CW-1:0]                         clear_color;
    logic                                  clear_busy;
    logic                                  clear_done;
    logic [15:0]                           oob_count;

    int tests_run    = 0;
    int tests_failed = 0;

    frame_buffer_mc_controller #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .NUM_WRITERS (NW),
        .COLOR_W     (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_x        (wr_x),
        .wr_y        (wr_y),
        .wr_color    (wr_color),
        .rd_en       (rd_en),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_valid    (rd_valid),
        .rd_color    (rd_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .oob_count   (oob_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Present a write on one channel and hold it until granted (bounded).
    task automatic do_write(input int ch, input int x, input int y, input logic [CW-1:0] c,
                            output bit ok);
        ok           = 1'b0;
        wr_x[ch]     = SCREEN_COORD'(x);
        wr_y[ch]     = SCREEN_COORD'(y);
        wr_color[ch] = c;
        wr_valid[ch] = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            #1;
            if (wr_ready[ch]) ok = 1'b1;
            @(posedge clk); #1;
        end
        wr_valid[ch] = 1'b0;
    endtask

    // Issue one read and return what appears two edges later.
    task automatic do_read(input int x, input int y, output logic [CW-1:0] c, output logic v);
        rd_x  = SCREEN_COORD'(x);
        rd_y  = SCREEN_COORD'(y);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
        v = rd_valid;
        c = rd_color;
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        wr_valid    = '1;
        wr_x        = '0;
        wr_y        = '0;
        wr_color    = '0;
        rd_en       = 1'b0;
        rd_x        = '0;
        rd_y        = '0;
        clear_req   = 1'b0;
        clear_color = '0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if (wr_ready !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_wr_ready got=%b exp=0000", wr_ready);
        end
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid);
        end
        tests_run++;
        if (rd_color !== 24'h0) begin
            tests_failed++; $display("FAIL reset_rd_color got=%h exp=000000", rd_color);
        end
        tests_run++;
        if (clear_busy !== 1'b0 || clear_done !== 1'b0) begin
            tests_failed++; $display("FAIL reset_clear got busy=%b done=%b exp 0/0", clear_busy, clear_done);
        end
        tests_run++;
        if (oob_count !== 16'h0) begin
            tests_failed++; $display("FAIL reset_oob_count got=%0d exp=0", oob_count);
        end
        wr_valid = '0;
        reset    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clear();
        int            busy;
        int            early_done;
        logic [CW-1:0] c;
        logic          v;
        busy        = 0;
        early_done  = 0;
        clear_color = 24'h0000FF;
        clear_req   = 1'b1;
        @(posedge clk); #1;
        clear_req   = 1'b0;
        clear_color = 24'h000000;
        wr_valid    = '1;
        for (int i = 0; i < 300; i++) begin
            if (!clear_busy) break;
            busy++;
            if (clear_done) early_done++;
            tests_run++;
            if (wr_ready !== 4'b0000) begin
                tests_failed++; $display("FAIL clear_wr_ready cycle=%0d got=%b exp=0000", busy, wr_ready);
            end
            if (busy == 10) begin
                clear_req   = 1'b1;
                clear_color = 24'hABCDEF;
            end else begin
                clear_req   = 1'b0;
                clear_color = 24'h000000;
            end
            @(posedge clk); #1;
        end
        wr_valid  = '0;
        clear_req = 1'b0;
        tests_run++;
        if (busy != 128) begin
            tests_failed++; $display("FAIL clear_busy_len got=%0d exp=128", busy);
        end
        tests_run++;
        if (clear_done !== 1'b1) begin
            tests_failed++; $display("FAIL clear_done_pulse got=%b exp=1", clear_done);
        end
        tests_run++;
        if (early_done != 0) begin
            tests_failed++; $display("FAIL clear_done_early got=%0d exp=0", early_done);
        end
        @(posedge clk); #1;
        tests_run++;
        if (clear_done !== 1'b0) begin
            tests_failed++; $display("FAIL clear_done_width got=%b exp=0", clear_done);
        end
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                do_read(x, y, c, v);
                tests_run++;
                if (v !== 1'b1 || c !== 24'h0000FF) begin
                    tests_failed++;
                    $display("FAIL clear_fill (%0d,%0d) got v=%b c=%h exp v=1 c=0000ff", x, y, v, c);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [CW-1:0] c;
        logic          v;
        for (int i = 0; i < NW; i++) begin
            wr_x[i]     = SCREEN_COORD'(i + 4);
            wr_y[i]     = SCREEN_COORD'(2);
            wr_color[i] = 24'hA00000 | 24'(i);
        end
        wr_valid = '1;
        for (int k = 0; k < NW; k++) begin
            #1;
            tests_run++;
            if (wr_ready !== 4'(1 << k)) begin
                tests_failed++; $display("FAIL b2b_grant step=%0d got=%b exp=%b", k, wr_ready, 4'(1 << k));
            end
            @(posedge clk); #1;
            wr_valid[k] = 1'b0;
        end
        for (int i = 0; i < NW; i++) begin
            do_read(i + 4, 2, c, v);
            tests_run++;
            if (v !== 1'b1 || c !== (24'hA00000 | 24'(i))) begin
                tests_failed++;
                $display("FAIL b2b_readback ch=%0d got v=%b c=%h exp v=1 c=%h", i, v, c, 24'hA00000 | 24'(i));
            end
        end
    endtask

    task automatic test_write_read();
        bit ok;
        do_write(0, 31, 0, 24'h112233, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL wr_handshake got=timeout exp=grant");
        end
        @(posedge clk); #1;
        rd_x  = SCREEN_COORD'(31);
        rd_y  = SCREEN_COORD'(0);
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_latency_early got=%b exp=0", rd_valid);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rd_valid !== 1'b1 || rd_color !== 24'h112233) begin
            tests_failed++; $display("FAIL rd_data got v=%b c=%h exp v=1 c=112233", rd_valid, rd_color);
        end
        @(posedge clk); #1;
        tests_run++;
        if (rd_valid !== 1'b0) begin
            tests_failed++; $display("FAIL rd_valid_width got=%b exp=0", rd_valid);
        end
    endtask

    task automatic test_oob();
        bit            ok;
        logic [CW-1:0] c;
        logic          v;
        do_write(1, 32, 0, 24'h123456, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL oob_x_handshake got=timeout exp=grant");
        end
        do_write(2, 0, 4, 24'h654321, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++; $display("FAIL oob_y_handshake got=timeout exp=grant");
        end
        tests_run++;
        if (oob_count !== 16'd2) begin
            tests_failed++; $display("FAIL oob_count got=%0d exp=2", oob_count);
        end
        do_read(0, 0, c, v);
        tests_run++;
        if (v !== 1'b1 || c !== 24'h0000FF) begin
            tests_failed++; $display("FAIL oob_origin got v=%b c=%h exp v=1 c=0000ff", v, c);
        end
        do_read(32, 0, c, v);
        tests_run++;
        if (v !== 1'b1 || c !== 24'h0) begin
            tests_failed++; $display("FAIL oob_read got v=%b c=%h exp v=1 c=000000", v, c);
        end
    endtask

    task automatic test_raw();
        wr_x[0]     = SCREEN_COORD'(0);
        wr_y[0]     = SCREEN_COORD'(1);
        wr_color[0] = 24'hC0FFEE;
        wr_valid[0] = 1'b1;
        rd_x        = SCREEN_COORD'(0);
        rd_y        = SCREEN_COORD'(1);
        rd_en       = 1'b1;
        #1;
        tests_run++;
        if (wr_ready !== 4'b0001) begin
            tests_failed++; $display("FAIL raw_grant got=%b exp=0001", wr_ready);
        end
        @(posedge clk); #1;
        wr_valid[0] = 1'b0;
        rd_en       = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (rd_valid !== 1'b1 || rd_color !== 24'h0000FF) begin
            tests_failed++; $display("FAIL raw_same_cycle got v=%b c=%h exp v=1 c=0000ff", rd_valid, rd_color);
        end
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (rd_valid !== 1'b1 || rd_color !== 24'hC0FFEE) begin
            tests_failed++; $display("FAIL raw_later got v=%b c=%h exp v=1 c=c0ffee", rd_valid, rd_color);
        end
    endtask

    task automatic test_reset_mid_clear();
        int            done_seen;
        logic [CW-1:0] c;
        logic          v;
        done_seen   = 0;
        clear_color = 24'h00FF00;
        clear_req   = 1'b1;
        @(posedge clk); #1;
        clear_req = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        tests_run++;
        if (clear_busy !== 1'b1) begin
            tests_failed++; $display("FAIL mid_clear_busy got=%b exp=1", clear_busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        tests_run++;
        if (clear_busy !== 1'b0) begin
            tests_failed++; $display("FAIL reset_clear_busy got=%b exp=0", clear_busy);
        end
        if (clear_done) done_seen++;
        wr_x[3]     = SCREEN_COORD'(5);
        wr_y[3]     = SCREEN_COORD'(3);
        wr_color[3] = 24'h5A5A5A;
        wr_valid[3] = 1'b1;
        #1;
        tests_run++;
        if (wr_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL reset_write_ready got=%b exp=1000", wr_ready);
        end
        @(posedge clk); #1;
        wr_valid[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (clear_done) done_seen++;
            @(posedge clk); #1;
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++; $display("FAIL reset_no_done got=%0d pulses exp=0", done_seen);
        end
        do_read(5, 3, c, v);
        tests_run++;
        if (v !== 1'b1 || c !== 24'h5A5A5A) begin
            tests_failed++; $display("FAIL reset_write_data got v=%b c=%h exp v=1 c=5a5a5a", v, c);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_back_to_back();
        test_write_read();
        test_oob();
        test_raw();
        test_reset_mid_clear();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
